alu_bit_sequencer: RTL and testbench

- Upstream driver for the 1-bit `simple_alu`.
- Accepts WIDTH-bit operand pairs plus an opcode over a valid/ready handshake.
- Streams operand bits LSB-first into the 1-bit ALU, one bit per clock, and collects the ALU result bits into a WIDTH-bit word.
- Returns the word on a valid/ready output; lets a single 1-bit ALU process multi-bit operands bit-serially.

---
 rtl/alu_bit_sequencer_if.sv | 33 +++
 rtl/alu_bit_sequencer.sv | 81 ++++++++
 tb/tb_alu_bit_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_bit_sequencer_if.sv
// Request, result and ALU-drive signals between alu_bit_sequencer and its surroundings.
// The slave view is the sequencer. The master view is the requester, consumer and 1-bit ALU.
interface alu_bit_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [SEL_W-1:0] in_op;

    logic             alu_a;
    logic             alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic             alu_result;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_op, alu_result, out_ready,
        output in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_err, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_op, alu_result, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_err, busy
    );
endinterface

// File: rtl/alu_bit_sequencer.sv
// Bit-serial driver for a 1-bit ALU. It feeds operand bits LSB-first, one per clock.
// It collects the result bits into a WIDTH-bit word and returns that word over valid/ready.
module alu_bit_sequencer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned MAX_OP = 8
) (
    input logic                clk,
    input logic                rst_n,
    alu_bit_sequencer_if.slave bus
);
    localparam int unsigned     IdxW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [IdxW-1:0]  idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [SEL_W-1:0] op_q;
    logic             err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.in_a;
                        b_q   <= bus.in_b;
                        op_q  <= bus.in_op;
                        idx_q <= '0;
                        res_q <= '0;
                        // An illegal opcode skips the ALU and reports an all-zero word.
                        if (32'(bus.in_op) <= MAX_OP) begin
                            err_q   <= 1'b0;
                            state_q <= StRun;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StRun: begin
                    res_q[idx_q] <= bus.alu_result;
                    if (idx_q == LastIdx) begin
                        idx_q   <= '0;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs are decoded from registered state only. They never depend on alu_result.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = res_q;
    assign bus.out_err   = err_q & (state_q == StDone);
    assign bus.alu_a     = (state_q == StRun) & a_q[idx_q];
    assign bus.alu_b     = (state_q == StRun) & b_q[idx_q];
    assign bus.alu_sel   = (state_q == StRun) ? op_q : '0;
endmodule

// File: tb/tb_alu_bit_sequencer.sv
// Bench for alu_bit_sequencer: drives a behavioural 1-bit ALU and checks every cycle
// against a word-level transaction model, plus literal expectations for the directed vectors.
module tb_alu_bit_sequencer;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned MAX_OP = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_bit_sequencer_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    alu_bit_sequencer #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W),
        .MAX_OP(MAX_OP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: timed out at t=%0t", name, $time);
    endtask

    // Behavioural 1-bit ALU
    function automatic logic alu_bit(input logic a, input logic b, input logic [SEL_W-1:0] sel);
        case (sel)
            4'd0:       return a & b;
            4'd1:       return a | b;
            4'd2:       return a ^ b;
            4'd3:       return ~a;
            4'd4:       return ~b;
            4'd5, 4'd6: return a ^ b;
            4'd7:       return a;
            4'd8:       return b;
            default:    return 1'b0;
        endcase
    endfunction

    assign bus.alu_result = alu_bit(bus.alu_a, bus.alu_b, bus.alu_sel);

    // Whole-word result expected for one request
    function automatic logic [WIDTH-1:0] ref_word(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [SEL_W-1:0] op);
        case (op)
            4'd0:       return a & b;
            4'd1:       return a | b;
            4'd2:       return a ^ b;
            4'd3:       return ~a;
            4'd4:       return ~b;
            4'd5, 4'd6: return a ^ b;
            4'd7:       return a;
            4'd8:       return b;
            default:    return '0;
        endcase
    endfunction

    // Transaction model: at most one outstanding request, stamped with its accept edge.
    int               cyc  = 0;
    int               acc  = 0;
    int               fv   = 0;
    logic             pend = 1'b0;
    logic             prev_v = 1'b0;
    logic [WIDTH-1:0] m_a  = '0;
    logic [WIDTH-1:0] m_b  = '0;
    logic [SEL_W-1:0] m_op = '0;
    logic [WIDTH-1:0] got_data[$];
    logic             got_err[$];
    int               got_lat[$];
    int               acc_hist[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                pend <= 1'b0;
                got_data.push_back(bus.out_data);
                got_err.push_back(bus.out_err);
                got_lat.push_back(fv - acc + 1);
            end
            if (bus.in_valid && bus.in_ready) begin
                pend <= 1'b1;
                acc  <= cyc + 1;
                m_a  <= bus.in_a;
                m_b  <= bus.in_b;
                m_op <= bus.in_op;
                acc_hist.push_back(cyc + 1);
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        int               n;
        logic             e_rdy, e_busy, e_val, e_err, e_a, e_b;
        logic [SEL_W-1:0] e_sel;
        logic [WIDTH-1:0] e_data;
        n      = cyc - acc;
        e_rdy  = 1'b1;
        e_busy = 1'b0;
        e_val  = 1'b0;
        e_err  = 1'b0;
        e_a    = 1'b0;
        e_b    = 1'b0;
        e_sel  = '0;
        e_data = '0;
        if (rst_n && pend) begin
            e_rdy  = 1'b0;
            e_busy = 1'b1;
            if (32'(m_op) > MAX_OP) begin
                e_val = 1'b1;
                e_err = 1'b1;
            end else if (n < int'(WIDTH)) begin
                e_a   = m_a[n];
                e_b   = m_b[n];
                e_sel = m_op;
            end else begin
                e_val  = 1'b1;
                e_data = ref_word(m_a, m_b, m_op);
            end
        end
        check("ctl", 32'({bus.in_ready, bus.busy, bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_sel}),
              32'({e_rdy, e_busy, e_val, e_a, e_b, e_sel}));
        if (e_val) begin
            check("result", 32'({bus.out_err, bus.out_data}), 32'({e_err, e_data}));
        end
        if (bus.out_valid && !prev_v) fv <= cyc;
        prev_v <= bus.out_valid;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [SEL_W-1:0] op);
        bit ok;
        ok = 1'b0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                @(posedge clk);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!ok) timeout("accept");
    endtask

    task automatic wait_results(input int count);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (got_data.size() >= count) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) timeout("result");
    endtask

    localparam logic [WIDTH-1:0] ExpData [10] =
        '{8'h24, 8'hBD, 8'h99, 8'h5A, 8'hC3, 8'hA5, 8'h3C, 8'hFE, 8'hFE, 8'h00};
    localparam logic [SEL_W-1:0] BtbOps [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};

    initial begin
        logic [WIDTH-1:0] exp_d;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'({bus.in_ready, bus.busy, bus.out_valid, bus.out_err, bus.out_data,
                                  bus.alu_a, bus.alu_b, bus.alu_sel}), 32'({1'b1, 17'd0}));
        #2 rst_n = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b1;

        // Back-to-back requests with the consumer always ready
        send(8'hA5, 8'h3C, 4'd0);
        for (int i = 0; i < 6; i++) send(8'hA5, 8'h3C, BtbOps[i]);
        send(8'hFF, 8'h01, 4'd5);
        send(8'hFF, 8'h01, 4'd6);
        send(8'hA5, 8'h3C, 4'd9);
        wait_results(10);
        for (int i = 0; i < 10; i++) begin
            exp_d = ExpData[i];
            check($sformatf("data[%0d]", i), 32'(got_data[i]), 32'(exp_d));
        end
        check("op0_latency", 32'(got_lat[0]), 32'd9);
        check("op0_err", 32'(got_err[0]), 32'd0);
        check("illegal_latency", 32'(got_lat[9]), 32'd1);
        check("illegal_err", 32'(got_err[9]), 32'd1);
        for (int i = 1; i < 9; i++) begin
            check($sformatf("accept_spacing[%0d]", i), 32'(acc_hist[i] - acc_hist[i-1]), 32'd10);
        end

        // Backpressure: result held while the consumer stalls; new requests are ignored
        bus.out_ready = 1'b0;
        send(8'hA5, 8'h3C, 4'd2);
        for (int k = 0; k < 20 && !bus.out_valid; k++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h11;
        bus.in_op    = 4'd0;
        repeat (5) @(negedge clk);
        check("bp_hold", 32'({bus.out_valid, bus.in_ready, bus.out_err, bus.out_data}),
              32'({1'b1, 1'b0, 1'b0, 8'h99}));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'({bus.out_valid, bus.in_ready}), 32'({1'b0, 1'b1}));
        wait_results(11);
        check("bp_data", 32'(got_data[10]), 32'h99);

        // Reset during the 4th RUN cycle aborts the request
        send(8'hA5, 8'h3C, 4'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_state", 32'({bus.in_ready, bus.busy, bus.out_valid, bus.out_err, bus.out_data,
                                  bus.alu_a, bus.alu_b, bus.alu_sel}), 32'({1'b1, 17'd0}));
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(8'h0F, 8'hF0, 4'd1);
        wait_results(12);
        check("post_reset_data", 32'(got_data[11]), 32'hFF);
        check("result_count", 32'(got_data.size()), 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
